data_memory_dumper: RTL
=======================

Name: data_memory_dumper

Overview:
- Read-side initiator for the data memory. On a start request, it walks the memory from address 0 to DUMP_WORDS-1.
- Each word is split into bytes and streamed MSB-first to the UART transmitter through a start/done handshake.
- Sits between the data memory read port and the debug UART TX. It is used to dump program results to the host after execution halts.

Parameters:
- RAM_WIDTH, 16, memory word width in bits; must be a multiple of 8.
- RAM_ADDR_BITS, 11, memory address width.
- DUMP_WORDS, 2048, number of words dumped, starting at address 0; range 1..2**RAM_ADDR_BITS.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- mem_write  output  1  write strobe to the memory; held 0 at all times.
- mem_addr  output  RAM_ADDR_BITS  address driven to the memory.
- mem_rdata  input  RAM_WIDTH  memory read data; the memory updates it on negedge.
- tx_data  output  8  byte to transmit; stable from tx_start until tx_done.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_done  input  1  one-cycle pulse from the UART TX when the byte has finished.
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- done  output  1  one-cycle pulse when the final byte's tx_done is received.

Behaviour:
- Reset values: mem_addr=0, tx_data=0, tx_start=0, busy=0, done=0, mem_write=0. Internal word/byte counters are 0 and the state is IDLE.
- BYTES = RAM_WIDTH/8; byte_idx counts from BYTES-1 down to 0. Byte k is mem_rdata[8k+7:8k].
- IDLE: on start=1, go to ADDR, set busy=1, mem_addr=0. start is ignored in every other state.
- ADDR: mem_addr is valid. The memory captures it at the following negedge. Go to LATCH.
- LATCH: register mem_rdata into the word buffer, set byte_idx=BYTES-1, go to SEND. Address-to-capture latency is 2 posedges.
- SEND: load tx_data with the selected buffer byte, pulse tx_start for exactly 1 cycle, go to WAIT_TX.
- WAIT_TX: hold tx_data and keep tx_start=0 until tx_done=1. tx_done pulses arriving in any other state are ignored.
  - If byte_idx>0: decrement byte_idx and go to SEND.
  - Else, if mem_addr==DUMP_WORDS-1: go to FINISH.
  - Else: increment mem_addr and go to ADDR.
- FINISH: pulse done for 1 cycle, clear busy, return to IDLE. mem_addr holds its last value until the next start.
- Address wrap: none. The dump stops at DUMP_WORDS-1. With DUMP_WORDS=2**RAM_ADDR_BITS, the last address is all-ones and the address never overflows.
- tx_done in the same cycle as tx_start: not legal, since the UART needs at least one cycle. The dumper does not sample tx_done in SEND.
- start asserted on the same cycle as done: ignored, because the FSM is not yet in IDLE.
- Reset asserted mid-dump: returns immediately to IDLE with all outputs at reset values. No partial-frame recovery; the host re-requests.
- Memory contents are never modified; mem_write is tied 0 through a register so it is glitch-free.
- Throughput per word: 2 + BYTES*(1 + T_tx) cycles, where T_tx is the number of cycles from tx_start to tx_done.

Optional Feature:
- DUMPER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator clears at start and XORs in every transmitted data byte.
  - After the last data byte's tx_done, the FSM enters a CHECKSUM state.
  - CHECKSUM sends the accumulator value as one extra byte with the same tx_start/tx_done handshake, then goes to FINISH.
  - Total bytes sent = DUMP_WORDS*BYTES + 1.
- Undefined: no accumulator logic; behaviour is exactly as above, with DUMP_WORDS*BYTES bytes sent.

Test Plan:
- Memory model with negedge read; preload addr0=0x1234, addr1=0xABCD; DUMP_WORDS=2; UART model returns tx_done 3 cycles after tx_start; start pulse -> tx_data sequence 0x12,0x34,0xAB,0xCD, 4 tx_start pulses, then done pulses once and busy drops.
- Same setup, continuous check -> mem_write stays 0 throughout and memory contents are unchanged after the dump.
- Stuck UART (tx_done withheld 500 cycles) -> tx_start pulses only once, and tx_data stays at 0x12 until tx_done arrives.
- Deassert rst_n after the 3rd byte's tx_start -> all outputs 0 asynchronously. A new start then restarts at addr 0 with first byte 0x12.
- start re-pulsed while busy=1 -> ignored: exactly 4 bytes are sent and there is one done pulse.
- With DUMPER_CHECKSUM_EN -> a 5th byte is sent with value 0x12^0x34^0xAB^0xCD=0x40, then done pulses.

Source files
------------

// File: rtl/data_memory_dumper.sv
// Streams data memory words 0..DUMP_WORDS-1 to a UART TX, one byte at a time, MSB byte first.
// Define DUMPER_CHECKSUM_EN to append an XOR checksum byte after the last data byte.
module data_memory_dumper #(
  parameter int unsigned RAM_WIDTH     = 16,
  parameter int unsigned RAM_ADDR_BITS = 11,
  parameter int unsigned DUMP_WORDS    = 2048
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     mem_write,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  input  logic [RAM_WIDTH-1:0]     mem_rdata,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_done,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned BYTES  = RAM_WIDTH / 8;
  localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0]        LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(DUMP_WORDS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;
`ifdef DUMPER_CHECKSUM_EN
  localparam logic [2:0] S_CHECKSUM = 3'd6;
  localparam logic [2:0] S_WAIT_CK  = 3'd7;
`endif

  logic [2:0]               state, state_nxt;
  logic [RAM_ADDR_BITS-1:0] addr_nxt;
  logic [RAM_WIDTH-1:0]     word_buf, word_nxt;
  logic [BIDX_W-1:0]        byte_idx, byte_idx_nxt;
  logic [7:0]               tx_data_nxt;
  logic                     tx_start_nxt, busy_nxt, done_nxt;
  logic [7:0]               sel_byte;
`ifdef DUMPER_CHECKSUM_EN
  logic [7:0]               xsum, xsum_nxt;
`endif

  // Byte byte_idx of the latched word
  assign sel_byte = 8'(word_buf >> {byte_idx, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      word_buf  <= '0;
      byte_idx  <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_write <= 1'b0;
`ifdef DUMPER_CHECKSUM_EN
      xsum      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      mem_addr  <= addr_nxt;
      word_buf  <= word_nxt;
      byte_idx  <= byte_idx_nxt;
      tx_data   <= tx_data_nxt;
      tx_start  <= tx_start_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      mem_write <= 1'b0;
`ifdef DUMPER_CHECKSUM_EN
      xsum      <= xsum_nxt;
`endif
    end
  end

  // Next-state and next-output logic; busy/done change on entry to FINISH
  always_comb begin
    state_nxt    = state;
    addr_nxt     = mem_addr;
    word_nxt     = word_buf;
    byte_idx_nxt = byte_idx;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
`ifdef DUMPER_CHECKSUM_EN
    xsum_nxt     = xsum;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ADDR;
          busy_nxt  = 1'b1;
          addr_nxt  = '0;
`ifdef DUMPER_CHECKSUM_EN
          xsum_nxt  = '0;
`endif
        end
      end
      S_ADDR:  state_nxt = S_LATCH;
      S_LATCH: begin
        word_nxt     = mem_rdata;
        byte_idx_nxt = LAST_BYTE;
        state_nxt    = S_SEND;
      end
      S_SEND: begin
        tx_data_nxt  = sel_byte;
        tx_start_nxt = 1'b1;
        state_nxt    = S_WAIT_TX;
`ifdef DUMPER_CHECKSUM_EN
        xsum_nxt     = xsum ^ sel_byte;
`endif
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          if (byte_idx != '0) begin
            byte_idx_nxt = byte_idx - BIDX_W'(1);
            state_nxt    = S_SEND;
          end else if (mem_addr == LAST_ADDR) begin
`ifdef DUMPER_CHECKSUM_EN
            state_nxt = S_CHECKSUM;
`else
            state_nxt = S_FINISH;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
`endif
          end else begin
            addr_nxt  = mem_addr + RAM_ADDR_BITS'(1);
            state_nxt = S_ADDR;
          end
        end
      end
`ifdef DUMPER_CHECKSUM_EN
      S_CHECKSUM: begin
        tx_data_nxt  = xsum;
        tx_start_nxt = 1'b1;
        state_nxt    = S_WAIT_CK;
      end
      S_WAIT_CK: begin
        if (tx_done) begin
          state_nxt = S_FINISH;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
`endif
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

endmodule
